// File: rtl/jtag_debug_scan_master.sv
// rtl/jtag_debug_scan_master.sv - virtual-JTAG debug scan initiator
//
// Purpose: accepts one command (IR value plus DR word), plays a complete
// update-IR / capture-DR / shift-DR / update-DR / run-test-idle sequence on
// the vji_* signal set with a divided test clock, and returns the captured
// DR word together with the target status seen at update-IR.
//
// Ports:
//   clk, reset                system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_ir, cmd_dr            instruction and DR word (DR shifted LSB first)
//   rsp_valid/rsp_ready       response handshake
//   rsp_dr, rsp_ir_out        captured DR word, vji_ir_out sampled in UIR
//   vji_tck, vji_tdi          generated test clock and serial data out
//   vji_tdo, vji_ir_out       serial data and status from the target
//   vji_ir_in                 instruction presented to the target
//   vji_uir .. vji_rti        one-hot virtual state strobes
module jtag_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int PERIOD = 2 * TCK_DIV;
  localparam int PH_W   = $clog2(PERIOD);
  localparam int BIT_W  = $clog2(DR_WIDTH);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UIR   = 3'd1,
    S_CDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_UDR   = 3'd4,
    S_RTI   = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic [4:0]          strb_q, strb_d;  // {uir, cdr, sdr, udr, rti}
  logic                scan_d;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    ir_in_d  = ir_in_q;
    rsp_ir_d = rsp_ir_q;
    rsp_dr_d = rsp_dr_q;
    tdi_d    = tdi_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = S_UIR;
          ph_d    = '0;
          sr_d    = cmd_dr;
          ir_in_d = cmd_ir;
        end
      end
      S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          case (state_q)
            S_UIR: state_d = S_CDR;
            S_CDR: begin
              state_d = S_SHIFT;
              bit_d   = '0;
            end
            S_SHIFT: begin
              if (bit_q == BIT_LAST) state_d = S_UDR;
              else                   bit_d   = bit_q + 1'b1;
            end
            S_UDR:   state_d = S_RTI;
            default: state_d = S_RESP;
          endcase
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_RESP: begin
        // rsp_valid_q gates the handshake so RESP always lasts >= 1 cycle
        if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    scan_d = (state_d == S_UIR) || (state_d == S_CDR) || (state_d == S_SHIFT) ||
             (state_d == S_UDR) || (state_d == S_RTI);

    // Sampling happens on the clk edge that raises vji_tck (phase PH_RISE).
    if (state_d == S_UIR && ph_d == PH_RISE) rsp_ir_d = vji_ir_out;
    if (state_d == S_SHIFT && ph_d == PH_RISE) sr_d = {vji_tdo, sr_q[DR_WIDTH-1:1]};

    // TDI changes only at the start of a low phase, so it is stable at the rise.
    if (state_d == S_SHIFT) begin
      if (ph_d == '0) tdi_d = sr_q[0];
    end else begin
      tdi_d = 1'b0;
    end

    if (state_q == S_RTI && state_d == S_RESP) rsp_dr_d = sr_q;

    tck_d       = scan_d && (ph_d >= PH_RISE);
    strb_d      = {state_d == S_UIR, state_d == S_CDR, state_d == S_SHIFT,
                   state_d == S_UDR, state_d == S_RTI};
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dr_q    <= '0;
      rsp_ir_q    <= '0;
      ir_in_q     <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      strb_q      <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dr_q    <= rsp_dr_d;
      rsp_ir_q    <= rsp_ir_d;
      ir_in_q     <= ir_in_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      strb_q      <= strb_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dr     = rsp_dr_q;
  assign rsp_ir_out = rsp_ir_q;
  assign vji_ir_in  = ir_in_q;
  assign vji_tck    = tck_q;
  assign vji_tdi    = tdi_q;
  assign vji_uir    = strb_q[4];
  assign vji_cdr    = strb_q[3];
  assign vji_sdr    = strb_q[2];
  assign vji_udr    = strb_q[1];
  assign vji_rti    = strb_q[0];

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// tb/tb_jtag_debug_scan_master.sv - randomized model-checked bench for jtag_debug_scan_master
module tb_jtag_debug_scan_master;

  localparam int DR  = 38;
  localparam int IRW = 2;
  localparam int TD  = 2;
  localparam int PER = 2 * TD;
  localparam int LAT = PER * (DR + 4);

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir;
  logic [DR-1:0]  cmd_dr;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DR-1:0]  rsp_dr;
  logic [IRW-1:0] rsp_ir_out;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IRW-1:0] vji_ir_in;
  logic [IRW-1:0] vji_ir_out;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic tdo_r, k_loop, k_tdo_one, k_ir_pat;
  assign vji_tdo = k_loop ? vji_tdi : tdo_r;

  jtag_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_DIV(TD)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  always #5 clk = ~clk;

  // Model: 0 = in/just out of reset, 1 = idle, 2 = scanning (m_j clks since accept), 3 = response
  int            m_mode, m_j;
  logic [DR-1:0] m_dr, m_cap, e_rsp;
  logic [1:0]    e_ir_in, e_ir_out;

  int nvec, nfail, ncyc, n_acc, acc_n;
  int c_uir, c_cdr, c_sdr, c_udr, c_rti, c_rise, c_ovl, c_rv;
  int f_uir, f_cdr, f_sdr, f_udr, f_rti, rv_first;
  logic prev_tck;

  task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic clear_stats();
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0; c_rise = 0; c_ovl = 0; c_rv = 0;
    f_uir = -1; f_cdr = -1; f_sdr = -1; f_udr = -1; f_rti = -1; rv_first = -1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_j = 0;
    e_rsp = '0; e_ir_in = '0; e_ir_out = '0;
  endtask

  // Applies the effect of the coming rising clk edge using the inputs now driven.
  task automatic advance();
    int jn, p, ph;
    logic tdo_now;
    tdo_now = k_loop ? vji_tdi : tdo_r;
    if (reset) begin
      model_reset();
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (cmd_valid) begin
          m_mode = 2; m_j = 0; e_ir_in = cmd_ir; m_dr = cmd_dr; m_cap = '0;
          acc_n = ncyc; n_acc++;
        end
        2: begin
          jn = m_j + 1;
          if (jn == LAT) begin
            m_mode = 3; e_rsp = m_cap;
          end else begin
            p = jn / PER; ph = jn % PER;
            if (ph == TD) begin
              if (p == 0) e_ir_out = vji_ir_out;
              else if (p >= 2 && p < DR + 2) m_cap[p-2] = tdo_now;
            end
          end
          m_j = jn;
        end
        default: if (rsp_ready) m_mode = 1;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic e_cr, e_rv, e_tck, e_tdi;
    logic [4:0] e_st;
    int p, ph, n_on;
    e_cr = (m_mode == 1); e_rv = (m_mode == 3); e_tck = 1'b0; e_tdi = 1'b0; e_st = '0;
    if (m_mode == 2) begin
      p = m_j / PER; ph = m_j % PER;
      e_tck = (ph >= TD);
      e_st  = {p == 0, p == 1, (p >= 2 && p < DR + 2), p == DR + 2, p == DR + 3};
      if (p >= 2 && p < DR + 2) e_tdi = m_dr[p-2];
    end
    check_vec("ctl{rdy,rv,tck,tdi,uir,cdr,sdr,udr,rti,ir_in,ir_out}",
              64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
                   vji_udr, vji_rti, vji_ir_in, rsp_ir_out}),
              64'({e_cr, e_rv, e_tck, e_tdi, e_st, e_ir_in, e_ir_out}));
    if (m_mode == 3) check_vec("rsp_dr", 64'(rsp_dr), 64'(e_rsp));
    if (m_mode == 0) check_vec("rsp_dr in reset", 64'(rsp_dr), 64'(0));
    n_on = int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti);
    if (n_on > 1) c_ovl++;
    if (vji_uir) begin c_uir++; if (f_uir < 0) f_uir = ncyc; end
    if (vji_cdr) begin c_cdr++; if (f_cdr < 0) f_cdr = ncyc; end
    if (vji_sdr) begin c_sdr++; if (f_sdr < 0) f_sdr = ncyc; end
    if (vji_udr) begin c_udr++; if (f_udr < 0) f_udr = ncyc; end
    if (vji_rti) begin c_rti++; if (f_rti < 0) f_rti = ncyc; end
    if (vji_sdr && vji_tck && !prev_tck) c_rise++;
    prev_tck = vji_tck;
    if (rsp_valid) begin c_rv++; if (rv_first < 0) rv_first = ncyc; end
  endtask

  task automatic drive_auto();
    tdo_r = k_tdo_one ? 1'b1 : 1'($urandom_range(0, 1));
    if (k_ir_pat) vji_ir_out = (m_mode == 2 && (m_j + 1) < PER) ? 2'b01 : 2'b11;
    else          vji_ir_out = 2'($urandom_range(0, 3));
  endtask

  task automatic step();
    drive_auto();
    advance();
    @(negedge clk);
    ncyc++;
    check_outputs();
  endtask

  task automatic reset_mid();
    drive_auto();
    advance();
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_vec("async reset outputs",
              64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
                   vji_udr, vji_rti, vji_ir_in, rsp_ir_out}), 64'(0));
    check_outputs();
  endtask

  task automatic send(input logic [1:0] ir, input logic [DR-1:0] dr);
    int n0;
    n0 = n_acc;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
    for (int i = 0; i < 400 && n_acc == n0; i++) step();
    if (n_acc == n0) begin
      nvec++; nfail++;
      $display("FAIL send: command not accepted within 400 clks");
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < LAT + 40 && !rsp_valid; i++) step();
    if (!rsp_valid) begin
      nvec++; nfail++;
      $display("FAIL wait_rsp: rsp_valid never rose, got 0, expected 1");
    end
  endtask

  initial begin
    int hs_n;
    nvec = 0; nfail = 0; ncyc = 0; n_acc = 0; acc_n = 0; prev_tck = 1'b0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b1;
    tdo_r = 1'b0; vji_ir_out = '0; k_loop = 1'b0; k_tdo_one = 1'b0; k_ir_pat = 1'b0;
    m_dr = '0; m_cap = '0;
    model_reset();
    clear_stats();

    // Reset values and release
    repeat (3) step();
    reset = 1'b0;
    step();
    check_vec("cmd_ready after release", 64'(cmd_ready), 64'(1));
    check_vec("rsp_valid after release", 64'(rsp_valid), 64'(0));
    reset_mid();
    step();
    reset = 1'b0;
    step();

    // Loopback with the reference word; rsp_ready already high before rsp_valid
    k_loop = 1'b1; rsp_ready = 1'b1;
    clear_stats();
    send(2'b10, 38'h2A_DEAD_BEEF);
    wait_rsp();
    check_vec("loopback rsp_dr", 64'(rsp_dr), 64'(38'h2A_DEAD_BEEF));
    check_vec("loopback vji_ir_in", 64'(vji_ir_in), 64'(2'b10));
    check_vec("loopback latency", 64'(rv_first - acc_n - 1), 64'(168));
    step();
    check_vec("resp lasts one cycle", 64'(c_rv), 64'(1));

    // Strobe timing with vji_tdo held at 1
    k_loop = 1'b0; k_tdo_one = 1'b1;
    clear_stats();
    send(2'($urandom_range(0, 3)), DR'({$urandom(), $urandom()}));
    wait_rsp();
    check_vec("sdr clks", 64'(c_sdr), 64'(152));
    check_vec("tck rises in sdr", 64'(c_rise), 64'(38));
    check_vec("uir/cdr/udr/rti clks", 64'({8'(c_uir), 8'(c_cdr), 8'(c_udr), 8'(c_rti)}),
              64'({8'd4, 8'd4, 8'd4, 8'd4}));
    check_vec("strobe order", 64'(f_uir < f_cdr && f_cdr < f_sdr && f_sdr < f_udr && f_udr < f_rti), 64'(1));
    check_vec("strobe overlap", 64'(c_ovl), 64'(0));
    check_vec("all-ones rsp_dr", 64'(rsp_dr), 64'(38'h3F_FFFF_FFFF));
    step();
    k_tdo_one = 1'b0;

    // IR capture: 01 during UIR, 11 elsewhere
    k_ir_pat = 1'b1;
    send(2'b01, DR'({$urandom(), $urandom()}));
    wait_rsp();
    check_vec("ir capture", 64'(rsp_ir_out), 64'(2'b01));
    step();
    k_ir_pat = 1'b0;

    // Backpressure with a second command waiting
    rsp_ready = 1'b0;
    send(2'b11, DR'({$urandom(), $urandom()}));
    wait_rsp();
    clear_stats();
    cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_dr = DR'({$urandom(), $urandom()});
    repeat (10) step();
    check_vec("rsp_valid held under backpressure", 64'(c_rv), 64'(10));
    rsp_ready = 1'b1;
    hs_n = n_acc;
    step();
    check_vec("idle after handshake", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    check_vec("no accept during stall", 64'(n_acc - hs_n), 64'(0));
    step();
    check_vec("second command accepted", 64'({cmd_ready, vji_uir}), 64'(2'b01));
    cmd_valid = 1'b0;
    wait_rsp();
    step();

    // Abort mid-shift, then a clean zero command in loopback
    k_loop = 1'b1;
    send(2'b10, DR'({$urandom(), $urandom()}));
    for (int i = 0; i < 400 && !(m_mode == 2 && m_j >= PER * 22); i++) step();
    reset_mid();
    step(); step();
    reset = 1'b0;
    step();
    clear_stats();
    send(2'b00, 38'h0);
    wait_rsp();
    check_vec("post-abort rsp_dr", 64'(rsp_dr), 64'(38'h0));
    repeat (60) step();
    check_vec("single response after abort", 64'(c_rv), 64'(1));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_ir    = 2'($urandom_range(0, 3));
      cmd_dr    = DR'({$urandom(), $urandom()});
      rsp_ready = ($urandom_range(0, 3) != 0);
      k_loop    = 1'($urandom_range(0, 1));
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
